// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-rate UART receiver.
package uart_pkg;

   localparam int CNT_W = 20;

   localparam int BAUD_TAB [8] = '{9600, 19200, 38400, 57600,
                                   115200, 230400, 460800, 921600};

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_CLEANUP
   } rx_state_t;

   // Clocks per bit for table entry idx, truncated; only ever evaluated on constants.
   function automatic logic [CNT_W-1:0] clks_per_bit(input int clk_hz, input int idx);
      return CNT_W'(clk_hz / BAUD_TAB[idx[2:0]]);
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial frame decoder: line synchroniser, bit-timing FSM and shift register.
// Build option: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic             i_UART_RX,
   input  logic [CNT_W-1:0] i_CPB,
   output logic             o_Idle,
   output logic             o_Busy,
   output logic             o_RX_DV,
   output logic             o_Frame_Err,
   output logic             o_Parity_Err,
   output logic [7:0]       o_RX_Byte
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   rx_state_t              state;
   logic [1:0]             sync;
   logic                   rx_s;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       half_m1;
   logic [CNT_W-1:0]       cpb_m1;
   logic [2:0]             bit_idx;
   logic [DATA_BITS-1:0]   sr;
   logic                   brk;
`ifdef UART_RX_PARITY_EN
   logic                   par_bad;
`endif

   assign rx_s    = sync[1];
   assign half_m1 = (i_CPB >> 1) - CNT_W'(1);
   assign cpb_m1  = i_CPB - CNT_W'(1);
   assign o_Idle  = (state == S_IDLE);

   // Two-flop synchroniser for the asynchronous line; resets to idle-high.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) sync <= 2'b11;
      else          sync <= {sync[0], i_UART_RX};
   end

   // Frame FSM: centre-samples each bit and raises the one-cycle result strobes.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state       <= S_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         sr          <= '0;
         brk         <= 1'b0;
         o_Busy      <= 1'b0;
         o_RX_DV     <= 1'b0;
         o_Frame_Err <= 1'b0;
         o_RX_Byte   <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad      <= 1'b0;
         o_Parity_Err <= 1'b0;
`endif
      end else begin
         o_RX_DV     <= 1'b0;
         o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_Parity_Err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               brk     <= 1'b0;
               if (!rx_s) begin
                  state  <= S_START;
                  o_Busy <= 1'b1;
               end
            end
            S_START: begin
               if (cnt == half_m1) begin
                  // A start bit that is high again at mid-bit was a glitch.
                  cnt    <= '0;
                  state  <= rx_s ? S_IDLE : S_DATA;
                  o_Busy <= !rx_s;
               end else cnt <= cnt + CNT_W'(1);
            end
            S_DATA: begin
               if (cnt == cpb_m1) begin
                  cnt     <= '0;
                  sr      <= {rx_s, sr[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (bit_idx == LAST_BIT) state <= S_PARITY;
`else
                  if (bit_idx == LAST_BIT) state <= S_STOP;
`endif
               end else cnt <= cnt + CNT_W'(1);
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == cpb_m1) begin
                  cnt     <= '0;
                  par_bad <= ^{sr, rx_s};
                  state   <= S_STOP;
               end else cnt <= cnt + CNT_W'(1);
            end
`endif
            S_STOP: begin
               if (cnt == cpb_m1) begin
                  cnt   <= '0;
                  state <= S_CLEANUP;
`ifdef UART_RX_PARITY_EN
                  o_Parity_Err <= par_bad;
                  if (rx_s && !par_bad) begin
`else
                  if (rx_s) begin
`endif
                     o_RX_DV   <= 1'b1;
                     o_RX_Byte <= 8'(sr);
                  end
                  if (!rx_s) begin
                     o_Frame_Err <= 1'b1;
                     brk         <= 1'b1;
                  end
               end else cnt <= cnt + CNT_W'(1);
            end
            S_CLEANUP: begin
               // After a framing error wait out a held-low (break) line.
               if (!brk || rx_s) begin
                  state  <= S_IDLE;
                  o_Busy <= 1'b0;
                  brk    <= 1'b0;
               end
            end
            default: begin
               state  <= S_IDLE;
               o_Busy <= 1'b0;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: rtl/uart_rx_multibaud.sv
// UART receiver with run-time baud selection from a fixed rate table.
// Build option: UART_RX_PARITY_EN enables even-parity checking in the core.
module uart_rx_multibaud
   import uart_pkg::*;
#(
   parameter int CLK_HZ      = 25000000,
   parameter int NUM_RATES   = 8,
   parameter int DATA_BITS   = 8,
   parameter int DEFAULT_IDX = 4
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_UART_RX,
   input  logic       i_Rate_Next,
   input  logic       i_Rate_Prev,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_Frame_Err,
   output logic       o_Parity_Err,
   output logic [2:0] o_Rate_Idx,
   output logic       o_Busy
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_RATES - 1);

   logic [7:0][CNT_W-1:0] cpb_tab;
   logic [CNT_W-1:0]      cpb;
   logic [2:0]            rate_idx;
   logic                  pend_vld;
   logic                  pend_up;
   logic                  idle;
   logic                  step;

   for (genvar g = 0; g < 8; g++) begin : g_tab
      assign cpb_tab[g] = clks_per_bit(CLK_HZ, g);
   end

   assign cpb        = cpb_tab[rate_idx];
   assign step       = i_Rate_Next ^ i_Rate_Prev;
   assign o_Rate_Idx = rate_idx;

   function automatic logic [2:0] stepped(input logic [2:0] idx, input logic up);
      if (up) return (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
      else    return (idx == 3'd0) ? LAST_IDX : idx - 3'd1;
   endfunction

   // Rate index: steps immediately while idle, otherwise parks the latest request until idle.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         rate_idx <= 3'(DEFAULT_IDX);
         pend_vld <= 1'b0;
         pend_up  <= 1'b0;
      end else if (idle) begin
         if (step)          rate_idx <= stepped(rate_idx, i_Rate_Next);
         else if (pend_vld) rate_idx <= stepped(rate_idx, pend_up);
         pend_vld <= 1'b0;
      end else if (step) begin
         pend_vld <= 1'b1;
         pend_up  <= i_Rate_Next;
      end
   end

   uart_rx_core #(
      .DATA_BITS (DATA_BITS)
   ) u_core (
      .i_Clk        (i_Clk),
      .i_Rst_L      (i_Rst_L),
      .i_UART_RX    (i_UART_RX),
      .i_CPB        (cpb),
      .o_Idle       (idle),
      .o_Busy       (o_Busy),
      .o_RX_DV      (o_RX_DV),
      .o_Frame_Err  (o_Frame_Err),
      .o_Parity_Err (o_Parity_Err),
      .o_RX_Byte    (o_RX_Byte)
   );

endmodule

// File: tb/tb_uart_rx_multibaud.sv
// Bench for uart_rx_multibaud: table-driven rate model, frame timing from bit arithmetic.
module tb_uart_rx_multibaud;

   localparam int CLK_HZ = 25000000;
   localparam int NR     = 8;
   localparam int DB     = 8;
   localparam int DEF    = 4;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int RATES [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

   logic       i_Clk = 1'b0, i_Rst_L = 1'b0, i_UART_RX = 1'b1;
   logic       i_Rate_Next = 1'b0, i_Rate_Prev = 1'b0;
   logic       o_RX_DV, o_Frame_Err, o_Parity_Err, o_Busy;
   logic [7:0] o_RX_Byte;
   logic [2:0] o_Rate_Idx;

   int pass_cnt = 0, chk_cnt = 0, cyc = 0;
   int dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, dv_cyc = 0;
   logic [7:0] dv_byte = 8'h00;
   int m_idx = DEF;
   logic [7:0] m_byte = 8'h00;

   uart_rx_multibaud #(.CLK_HZ(CLK_HZ), .NUM_RATES(NR), .DATA_BITS(DB), .DEFAULT_IDX(DEF)) dut (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_UART_RX(i_UART_RX),
      .i_Rate_Next(i_Rate_Next), .i_Rate_Prev(i_Rate_Prev),
      .o_RX_DV(o_RX_DV), .o_RX_Byte(o_RX_Byte), .o_Frame_Err(o_Frame_Err),
      .o_Parity_Err(o_Parity_Err), .o_Rate_Idx(o_Rate_Idx), .o_Busy(o_Busy));

   always #20 i_Clk = ~i_Clk;
   always @(posedge i_Clk) cyc <= cyc + 1;

   // Strobe monitor, sampled mid-cycle.
   always @(negedge i_Clk) begin
      if (o_RX_DV) begin dv_cnt++; dv_cyc = cyc; dv_byte = o_RX_Byte; end
      if (o_Frame_Err) fe_cnt++;
      if (o_Parity_Err) pe_cnt++;
   end

   function automatic int cpb_of(input int idx);
      return CLK_HZ / RATES[idx];
   endfunction

   function automatic int dv_lat(input int cpb);
      return 3 + cpb / 2 + (DB + 1 + PB) * cpb;
   endfunction

   task automatic pulse(input logic nxt, input logic prv);
      @(posedge i_Clk); #1;
      i_Rate_Next = nxt; i_Rate_Prev = prv;
      @(posedge i_Clk); #1;
      i_Rate_Next = 1'b0; i_Rate_Prev = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input int cpb, input logic stop,
                             input logic par_flip, output int fall);
      @(posedge i_Clk); #1;
      i_UART_RX = 1'b0; fall = cyc;
      repeat (cpb) @(posedge i_Clk); #1;
      for (int i = 0; i < DB; i++) begin
         i_UART_RX = d[i];
         repeat (cpb) @(posedge i_Clk); #1;
      end
      if (PB == 1) begin
         i_UART_RX = (^d) ^ par_flip;
         repeat (cpb) @(posedge i_Clk); #1;
      end
      i_UART_RX = stop;
      repeat (cpb) @(posedge i_Clk); #1;
   endtask

   task automatic set_idx(input int target);
      for (int n = 0; n < NR && m_idx != target; n++) begin
         pulse(1'b1, 1'b0);
         m_idx = (m_idx + 1) % NR;
         chk_cnt++; if (o_Rate_Idx !== 3'(m_idx)) $display("FAIL set_idx: got %0d want %0d", o_Rate_Idx, m_idx); else pass_cnt++;
      end
   endtask

   task automatic test_reset;
      repeat (4) @(posedge i_Clk); #1;
      i_Rst_L = 1'b1;
      repeat (3) @(posedge i_Clk); #1;
      chk_cnt++; if (o_RX_DV !== 1'b0) $display("FAIL reset_dv: got %b want 0", o_RX_DV); else pass_cnt++;
      chk_cnt++; if (o_RX_Byte !== 8'h00) $display("FAIL reset_byte: got %h want 00", o_RX_Byte); else pass_cnt++;
      chk_cnt++; if (o_Rate_Idx !== 3'(DEF)) $display("FAIL reset_idx: got %0d want %0d", o_Rate_Idx, DEF); else pass_cnt++;
      chk_cnt++; if (o_Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_Busy); else pass_cnt++;
      chk_cnt++; if ({o_Frame_Err, o_Parity_Err} !== 2'b00) $display("FAIL reset_err: got %b want 00", {o_Frame_Err, o_Parity_Err}); else pass_cnt++;
   endtask

   task automatic test_basic;
      int fall, d0;
      d0 = dv_cnt;
      send_frame(8'hA5, cpb_of(m_idx), 1'b1, 1'b0, fall);
      m_byte = 8'hA5;
      chk_cnt++; if (dv_cnt - d0 !== 1) $display("FAIL basic_dv_count: got %0d want 1", dv_cnt - d0); else pass_cnt++;
      chk_cnt++; if (o_RX_Byte !== m_byte) $display("FAIL basic_byte: got %h want %h", o_RX_Byte, m_byte); else pass_cnt++;
      chk_cnt++; if (dv_cyc - fall !== dv_lat(cpb_of(m_idx))) $display("FAIL basic_latency: got %0d want %0d", dv_cyc - fall, dv_lat(cpb_of(m_idx))); else pass_cnt++;
      chk_cnt++; if (o_Rate_Idx !== 3'd4) $display("FAIL basic_idx: got %0d want 4", o_Rate_Idx); else pass_cnt++;
   endtask

   task automatic test_rate_wrap;
      int fall, d0;
      set_idx(0);
      d0 = dv_cnt;
      send_frame(8'h3C, cpb_of(m_idx), 1'b1, 1'b0, fall);
      m_byte = 8'h3C;
      chk_cnt++; if (dv_cnt - d0 !== 1) $display("FAIL wrap_dv_count: got %0d want 1", dv_cnt - d0); else pass_cnt++;
      chk_cnt++; if (dv_byte !== m_byte) $display("FAIL wrap_byte: got %h want %h", dv_byte, m_byte); else pass_cnt++;
      chk_cnt++; if (dv_cyc - fall !== dv_lat(cpb_of(0))) $display("FAIL wrap_latency: got %0d want %0d", dv_cyc - fall, dv_lat(cpb_of(0))); else pass_cnt++;
      for (int n = 0; n < 4; n++) begin
         pulse(1'b0, 1'b1);
         m_idx = (m_idx + NR - 1) % NR;
         chk_cnt++; if (o_Rate_Idx !== 3'(m_idx)) $display("FAIL wrap_prev: got %0d want %0d", o_Rate_Idx, m_idx); else pass_cnt++;
      end
   endtask

   task automatic test_midframe_rate;
      int fall, d0, old_cpb;
      d0 = dv_cnt;
      old_cpb = cpb_of(m_idx);
      fork
         send_frame(8'h55, old_cpb, 1'b1, 1'b0, fall);
         begin
            repeat (700) @(posedge i_Clk); #1;
            pulse(1'b1, 1'b0);
            chk_cnt++; if (o_Rate_Idx !== 3'(m_idx)) $display("FAIL mid_idx_held: got %0d want %0d", o_Rate_Idx, m_idx); else pass_cnt++;
            chk_cnt++; if (o_Busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", o_Busy); else pass_cnt++;
         end
      join
      m_idx = (m_idx + 1) % NR;
      m_byte = 8'h55;
      chk_cnt++; if (dv_cnt - d0 !== 1) $display("FAIL mid_dv_count: got %0d want 1", dv_cnt - d0); else pass_cnt++;
      chk_cnt++; if (dv_byte !== m_byte) $display("FAIL mid_byte: got %h want %h", dv_byte, m_byte); else pass_cnt++;
      chk_cnt++; if (dv_cyc - fall !== dv_lat(old_cpb)) $display("FAIL mid_latency: got %0d want %0d", dv_cyc - fall, dv_lat(old_cpb)); else pass_cnt++;
      chk_cnt++; if (o_Rate_Idx !== 3'(m_idx)) $display("FAIL mid_idx_applied: got %0d want %0d", o_Rate_Idx, m_idx); else pass_cnt++;
      pulse(1'b1, 1'b1);
      chk_cnt++; if (o_Rate_Idx !== 3'(m_idx)) $display("FAIL both_pulses: got %0d want %0d", o_Rate_Idx, m_idx); else pass_cnt++;
      pulse(1'b0, 1'b1);
      m_idx = (m_idx + NR - 1) % NR;
      chk_cnt++; if (o_Rate_Idx !== 3'(m_idx)) $display("FAIL mid_prev: got %0d want %0d", o_Rate_Idx, m_idx); else pass_cnt++;
   endtask

   task automatic test_frame_err;
      int fall, d0, f0, cpb;
      cpb = cpb_of(m_idx);
      d0 = dv_cnt; f0 = fe_cnt;
      send_frame(8'h0F, cpb, 1'b0, 1'b0, fall);
      repeat (20 * cpb) @(posedge i_Clk); #1;
      chk_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL ferr_count: got %0d want 1", fe_cnt - f0); else pass_cnt++;
      chk_cnt++; if (dv_cnt - d0 !== 0) $display("FAIL ferr_no_dv: got %0d want 0", dv_cnt - d0); else pass_cnt++;
      chk_cnt++; if (o_RX_Byte !== m_byte) $display("FAIL ferr_byte_held: got %h want %h", o_RX_Byte, m_byte); else pass_cnt++;
      chk_cnt++; if (o_Busy !== 1'b1) $display("FAIL break_busy: got %b want 1", o_Busy); else pass_cnt++;
      i_UART_RX = 1'b1;
      repeat (3 * cpb) @(posedge i_Clk); #1;
      chk_cnt++; if (o_Busy !== 1'b0) $display("FAIL break_release: got %b want 0", o_Busy); else pass_cnt++;
      chk_cnt++; if (fe_cnt - f0 !== 1 || dv_cnt - d0 !== 0) $display("FAIL break_strobes: got fe %0d dv %0d want 1 0", fe_cnt - f0, dv_cnt - d0); else pass_cnt++;
   endtask

   task automatic test_glitch;
      int d0, f0, p0;
      d0 = dv_cnt; f0 = fe_cnt; p0 = pe_cnt;
      @(posedge i_Clk); #1;
      i_UART_RX = 1'b0;
      repeat (50) @(posedge i_Clk); #1;
      chk_cnt++; if (o_Busy !== 1'b1) $display("FAIL glitch_busy: got %b want 1", o_Busy); else pass_cnt++;
      repeat (50) @(posedge i_Clk); #1;
      i_UART_RX = 1'b1;
      repeat (300) @(posedge i_Clk); #1;
      chk_cnt++; if (o_Busy !== 1'b0) $display("FAIL glitch_idle: got %b want 0", o_Busy); else pass_cnt++;
      chk_cnt++; if (dv_cnt != d0 || fe_cnt != f0 || pe_cnt != p0) $display("FAIL glitch_strobes: got %0d %0d %0d want 0 0 0", dv_cnt - d0, fe_cnt - f0, pe_cnt - p0); else pass_cnt++;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int fall, d0, p0;
      d0 = dv_cnt; p0 = pe_cnt;
      send_frame(8'h07, cpb_of(m_idx), 1'b1, 1'b1, fall);
      chk_cnt++; if (pe_cnt - p0 !== 1) $display("FAIL parity_err: got %0d want 1", pe_cnt - p0); else pass_cnt++;
      chk_cnt++; if (dv_cnt - d0 !== 0) $display("FAIL parity_no_dv: got %0d want 0", dv_cnt - d0); else pass_cnt++;
      chk_cnt++; if (o_RX_Byte !== m_byte) $display("FAIL parity_byte_held: got %h want %h", o_RX_Byte, m_byte); else pass_cnt++;
   endtask
`endif

   task automatic test_reset_midframe;
      set_idx(6);
      @(posedge i_Clk); #1;
      i_UART_RX = 1'b0;
      repeat (300) @(posedge i_Clk); #1;
      pulse(1'b1, 1'b0);
      chk_cnt++; if (o_Rate_Idx !== 3'd6) $display("FAIL rst_pending_held: got %0d want 6", o_Rate_Idx); else pass_cnt++;
      i_Rst_L = 1'b0;
      #1;
      chk_cnt++; if (o_RX_Byte !== 8'h00) $display("FAIL rst_mid_byte: got %h want 00", o_RX_Byte); else pass_cnt++;
      chk_cnt++; if (o_Rate_Idx !== 3'(DEF)) $display("FAIL rst_mid_idx: got %0d want %0d", o_Rate_Idx, DEF); else pass_cnt++;
      chk_cnt++; if ({o_Busy, o_RX_DV, o_Frame_Err, o_Parity_Err} !== 4'b0000) $display("FAIL rst_mid_flags: got %b want 0000", {o_Busy, o_RX_DV, o_Frame_Err, o_Parity_Err}); else pass_cnt++;
      i_UART_RX = 1'b1;
      repeat (5) @(posedge i_Clk); #1;
      i_Rst_L = 1'b1;
      m_idx = DEF; m_byte = 8'h00;
      repeat (10) @(posedge i_Clk); #1;
      chk_cnt++; if (o_Rate_Idx !== 3'(DEF)) $display("FAIL rst_pending_cleared: got %0d want %0d", o_Rate_Idx, DEF); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int fall, d0, cpb;
      logic [7:0] d;
      for (int r = 0; r < 3; r++) begin
         set_idx($urandom_range(4, 7));
         cpb = cpb_of(m_idx);
         for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            d0 = dv_cnt;
            send_frame(d, cpb, 1'b1, 1'b0, fall);
            m_byte = d;
            chk_cnt++; if (dv_cnt - d0 !== 1) $display("FAIL b2b_dv_count: got %0d want 1 (idx %0d)", dv_cnt - d0, m_idx); else pass_cnt++;
            chk_cnt++; if (dv_byte !== m_byte) $display("FAIL b2b_byte: got %h want %h (idx %0d)", dv_byte, m_byte, m_idx); else pass_cnt++;
            chk_cnt++; if (dv_cyc - fall !== dv_lat(cpb)) $display("FAIL b2b_latency: got %0d want %0d", dv_cyc - fall, dv_lat(cpb)); else pass_cnt++;
         end
         repeat (8) @(posedge i_Clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rate_wrap();
      test_midframe_rate();
      test_frame_err();
      test_glitch();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_reset_midframe();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
